// File: rtl/token_pipe_nch.sv
// token_pipe_nch
//   Per-channel token ring buffers with a latency countdown on every stored
//   entry. Heads whose countdown reaches zero compete for a single output.
//   The oldest token wins, where age is measured against I_Issue_No modulo
//   2^WIDTH_ISSUE, and the lowest channel index breaks ties.
//
// Ports
//   clock          : single clock, all state on the rising edge
//   reset          : synchronous, active-low
//   I_Valid        : push request
//   I_Ch           : target channel of the push
//   I_Lat          : cycles until the pushed token matures
//   I_Token_Issue  : issue number of the pushed token
//   I_Token        : payload of the pushed token
//   I_Issue_No     : current issue number, the age reference
//   I_Stall        : downstream stall; nothing pops while it is high
//   I_Flush        : (TOKEN_PIPE_NCH_FLUSH_EN only) empties every channel
//   O_Valid        : an eligible winner is presented
//   O_Ch           : source channel of the winner
//   O_Token_Issue  : issue number of the winner
//   O_Token        : payload of the winner
//   O_Full         : per-channel full flags, decoded from registered counts
//   O_Stall        : I_Valid & O_Full[I_Ch]
//
// Build option
//   TOKEN_PIPE_NCH_FLUSH_EN : adds the I_Flush port and its clear path.
module token_pipe_nch #(
  parameter int NUM_CH      = 4,
  parameter int DEPTH       = 8,
  parameter int WIDTH_TOKEN = 32,
  parameter int WIDTH_ISSUE = 8,
  parameter int WIDTH_LAT   = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_Valid,
  input  logic [CH_W-1:0]        I_Ch,
  input  logic [WIDTH_LAT-1:0]   I_Lat,
  input  logic [WIDTH_ISSUE-1:0] I_Token_Issue,
  input  logic [WIDTH_TOKEN-1:0] I_Token,
  input  logic [WIDTH_ISSUE-1:0] I_Issue_No,
  input  logic                   I_Stall,
`ifdef TOKEN_PIPE_NCH_FLUSH_EN
  input  logic                   I_Flush,
`endif
  output logic                   O_Valid,
  output logic [CH_W-1:0]        O_Ch,
  output logic [WIDTH_ISSUE-1:0] O_Token_Issue,
  output logic [WIDTH_TOKEN-1:0] O_Token,
  output logic [NUM_CH-1:0]      O_Full,
  output logic                   O_Stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH_ISSUE-1:0] issue_q  [NUM_CH][DEPTH];
  logic [WIDTH_ISSUE-1:0] issue_d  [NUM_CH][DEPTH];
  logic [WIDTH_TOKEN-1:0] token_q  [NUM_CH][DEPTH];
  logic [WIDTH_TOKEN-1:0] token_d  [NUM_CH][DEPTH];
  logic [WIDTH_LAT-1:0]   lat_q    [NUM_CH][DEPTH];
  logic [WIDTH_LAT-1:0]   lat_d    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]       wr_ptr_d [NUM_CH];
  logic [PTR_W-1:0]       rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0]       rd_ptr_d [NUM_CH];
  logic [CNT_W-1:0]       cnt_q    [NUM_CH];
  logic [CNT_W-1:0]       cnt_d    [NUM_CH];

  logic                   clear;
  logic                   in_full;
  logic                   in_hit;
  logic                   push_ok;
  logic                   pop;
  logic                   push_c;
  logic                   pop_c;
  logic                   head_elig;
  logic [WIDTH_ISSUE-1:0] age;
  logic [WIDTH_ISSUE-1:0] best_age;
  logic                   win_vld;
  logic [CH_W-1:0]        win_ch;
  logic [WIDTH_ISSUE-1:0] win_iss;
  logic [WIDTH_TOKEN-1:0] win_tok;

`ifdef TOKEN_PIPE_NCH_FLUSH_EN
  // Flush empties the channels exactly like reset and overrides push/pop.
  assign clear = !reset || I_Flush;
`else
  assign clear = !reset;
`endif

  // Wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    O_Full  = '0;
    in_full = 1'b0;
    in_hit  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      O_Full[c] = (cnt_q[c] == CNT_W'(DEPTH));
      if (I_Ch == CH_W'(c)) begin
        in_full = (cnt_q[c] == CNT_W'(DEPTH));
        in_hit  = 1'b1;
      end
    end
  end

  // A full channel refuses the push even if it pops this same cycle.
  assign O_Stall = I_Valid & in_full;
  assign push_ok = I_Valid & in_hit & !in_full;

  // Oldest eligible head wins; strict '>' keeps the lowest index on ties.
  always_comb begin
    win_vld   = 1'b0;
    win_ch    = '0;
    win_iss   = '0;
    win_tok   = '0;
    best_age  = '0;
    head_elig = 1'b0;
    age       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      head_elig = (cnt_q[c] != '0) && (lat_q[c][rd_ptr_q[c]] == '0);
      age       = I_Issue_No - issue_q[c][rd_ptr_q[c]];
      if (head_elig && (!win_vld || (age > best_age))) begin
        win_vld  = 1'b1;
        win_ch   = CH_W'(c);
        win_iss  = issue_q[c][rd_ptr_q[c]];
        win_tok  = token_q[c][rd_ptr_q[c]];
        best_age = age;
      end
    end
  end

  assign O_Valid       = win_vld;
  assign O_Ch          = win_ch;
  assign O_Token_Issue = win_iss;
  assign O_Token       = win_tok;
  assign pop           = win_vld & !I_Stall;

  always_comb begin
    issue_d  = issue_q;
    token_d  = token_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push_c   = 1'b0;
    pop_c    = 1'b0;
    // Countdown runs every cycle, stalled or not, and saturates at zero.
    for (int c = 0; c < NUM_CH; c++) begin
      for (int e = 0; e < DEPTH; e++) begin
        lat_d[c][e] = (lat_q[c][e] != '0) ? lat_q[c][e] - WIDTH_LAT'(1) : '0;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      push_c = push_ok && (I_Ch == CH_W'(c));
      pop_c  = pop && (win_ch == CH_W'(c));
      if (push_c) begin
        issue_d[c][wr_ptr_q[c]] = I_Token_Issue;
        token_d[c][wr_ptr_q[c]] = I_Token;
        lat_d[c][wr_ptr_q[c]]   = I_Lat;
        wr_ptr_d[c]             = ptr_inc(wr_ptr_q[c]);
      end
      if (pop_c) begin
        rd_ptr_d[c] = ptr_inc(rd_ptr_q[c]);
      end
      cnt_d[c] = cnt_q[c] + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          lat_q[c][e] <= '0;
        end
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
    end
  end

  // Payload storage needs no clear: an entry is only read while counted.
  always_ff @(posedge clock) begin
    issue_q <= issue_d;
    token_q <= token_d;
  end

endmodule

// File: tb/tb_token_pipe_nch.sv
module tb_token_pipe_nch;

  logic        clock = 1'b0;
  logic        reset;
  logic        I_Valid;
  logic [1:0]  I_Ch;
  logic [3:0]  I_Lat;
  logic [7:0]  I_Token_Issue;
  logic [31:0] I_Token;
  logic [7:0]  I_Issue_No;
  logic        I_Stall;
`ifdef TOKEN_PIPE_NCH_FLUSH_EN
  logic        I_Flush;
`endif
  logic        O_Valid;
  logic [1:0]  O_Ch;
  logic [7:0]  O_Token_Issue;
  logic [31:0] O_Token;
  logic [3:0]  O_Full;
  logic        O_Stall;

  token_pipe_nch dut (
    .clock        (clock),
    .reset        (reset),
    .I_Valid      (I_Valid),
    .I_Ch         (I_Ch),
    .I_Lat        (I_Lat),
    .I_Token_Issue(I_Token_Issue),
    .I_Token      (I_Token),
    .I_Issue_No   (I_Issue_No),
    .I_Stall      (I_Stall),
`ifdef TOKEN_PIPE_NCH_FLUSH_EN
    .I_Flush      (I_Flush),
`endif
    .O_Valid      (O_Valid),
    .O_Ch         (O_Ch),
    .O_Token_Issue(O_Token_Issue),
    .O_Token      (O_Token),
    .O_Full       (O_Full),
    .O_Stall      (O_Stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  ch;
    logic [7:0]  iss;
    logic [31:0] tok;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_tok(input logic [1:0] ch, input logic [7:0] iss, input logic [31:0] tok);
    exp_t e;
    e.ch  = ch;
    e.iss = iss;
    e.tok = tok;
    exp_q.push_back(e);
  endtask

  // One-cycle push, then idle the push request.
  task automatic push(input logic [1:0] ch, input logic [3:0] lat,
                      input logic [7:0] iss, input logic [31:0] tok);
    I_Valid       = 1'b1;
    I_Ch          = ch;
    I_Lat         = lat;
    I_Token_Issue = iss;
    I_Token       = tok;
    step();
    I_Valid = 1'b0;
  endtask

  // Release the stall for n cycles, then the scoreboard must be drained.
  task automatic drain(input string nm, input int n);
    I_Stall = 1'b0;
    repeat (n) step();
    @(negedge clock);
    chk({nm, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_idle_valid"}, 64'(O_Valid), 64'd0);
    step();
  endtask

  // Monitor: every cycle that pops is compared with the scoreboard head.
  always @(negedge clock) begin
    if (reset === 1'b1 && O_Valid === 1'b1 && I_Stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("mon_unexpected_valid", 64'(O_Valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_ch", 64'(O_Ch), 64'(e.ch));
        chk("mon_issue", 64'(O_Token_Issue), 64'(e.iss));
        chk("mon_token", 64'(O_Token), 64'(e.tok));
      end
    end
  end

  initial begin
    reset         = 1'b0;
    I_Valid       = 1'b1;
    I_Ch          = 2'd0;
    I_Lat         = 4'd0;
    I_Token_Issue = 8'd1;
    I_Token       = 32'hDEAD;
    I_Issue_No    = 8'd0;
    I_Stall       = 1'b0;
`ifdef TOKEN_PIPE_NCH_FLUSH_EN
    I_Flush       = 1'b0;
`endif

    // Reset with a push held high: the push must be discarded.
    repeat (3) step();
    reset   = 1'b1;
    I_Valid = 1'b0;
    @(negedge clock);
    chk("rst_valid", 64'(O_Valid), 64'd0);
    chk("rst_full", 64'(O_Full), 64'd0);
    chk("rst_stall", 64'(O_Stall), 64'd0);
    chk("rst_token", 64'(O_Token), 64'd0);
    chk("rst_ch", 64'(O_Ch), 64'd0);
    chk("rst_issue", 64'(O_Token_Issue), 64'd0);
    step();
    step();
    @(negedge clock);
    chk("rst_push_dropped", 64'(O_Valid), 64'd0);
    step();

    // Latency: push at cycle 0 with Lat=3, first visible at cycle 4.
    I_Stall    = 1'b1;
    I_Issue_No = 8'd5;
    push(2'd1, 4'd3, 8'd5, 32'hA5);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk($sformatf("lat_early_c%0d", k), 64'(O_Valid), 64'd0);
      step();
    end
    @(negedge clock);
    chk("lat_c4_valid", 64'(O_Valid), 64'd1);
    chk("lat_c4_ch", 64'(O_Ch), 64'd1);
    chk("lat_c4_token", 64'(O_Token), 64'hA5);
    chk("lat_c4_issue", 64'(O_Token_Issue), 64'd5);
    step();
    @(negedge clock);
    chk("lat_stall_hold_valid", 64'(O_Valid), 64'd1);
    chk("lat_stall_hold_token", 64'(O_Token), 64'hA5);
    step();
    expect_tok(2'd1, 8'd5, 32'hA5);
    drain("lat", 3);

    // Fill ch0 under stall; the ninth push is refused and never appears.
    I_Stall    = 1'b1;
    I_Issue_No = 8'd30;
    for (int i = 0; i < 8; i++) begin
      push(2'd0, 4'd0, 8'(20 + i), 32'h100 + 32'(i));
      expect_tok(2'd0, 8'(20 + i), 32'h100 + 32'(i));
    end
    @(negedge clock);
    chk("full_flag", 64'(O_Full), 64'b0001);
    chk("full_no_stall_idle", 64'(O_Stall), 64'd0);
    step();
    I_Valid       = 1'b1;
    I_Ch          = 2'd0;
    I_Token_Issue = 8'd28;
    I_Token       = 32'h1FF;
    @(negedge clock);
    chk("full_ostall", 64'(O_Stall), 64'd1);
    step();
    I_Valid = 1'b0;
    drain("full", 12);
    @(negedge clock);
    chk("full_cleared", 64'(O_Full), 64'd0);
    step();

    // Age arbitration: issue 7 is older than issue 10 at I_Issue_No=12.
    I_Stall    = 1'b1;
    I_Issue_No = 8'd12;
    push(2'd0, 4'd0, 8'd10, 32'hC0);
    push(2'd2, 4'd0, 8'd7, 32'hC2);
    expect_tok(2'd2, 8'd7, 32'hC2);
    expect_tok(2'd0, 8'd10, 32'hC0);
    drain("age", 4);

    // Equal age: lowest channel index wins.
    I_Stall    = 1'b1;
    I_Issue_No = 8'd12;
    push(2'd3, 4'd0, 8'd9, 32'hD3);
    push(2'd1, 4'd0, 8'd9, 32'hD1);
    expect_tok(2'd1, 8'd9, 32'hD1);
    expect_tok(2'd3, 8'd9, 32'hD3);
    drain("tie", 4);

    // Modular age: at I_Issue_No=2, issue 250 (age 8) beats issue 1 (age 1).
    I_Stall    = 1'b1;
    I_Issue_No = 8'd2;
    push(2'd0, 4'd0, 8'd1, 32'hE0);
    push(2'd2, 4'd0, 8'd250, 32'hE2);
    expect_tok(2'd2, 8'd250, 32'hE2);
    expect_tok(2'd0, 8'd1, 32'hE0);
    drain("wrap_age", 4);

    // Pointer wrap: fill ch0, pop once, then 20 push+pop cycles.
    I_Stall    = 1'b1;
    I_Issue_No = 8'd100;
    for (int i = 0; i < 8; i++) begin
      push(2'd0, 4'd0, 8'(40 + i), 32'h200 + 32'(i));
      expect_tok(2'd0, 8'(40 + i), 32'h200 + 32'(i));
    end
    I_Stall = 1'b0;
    step();
    for (int k = 0; k < 20; k++) begin
      expect_tok(2'd0, 8'(60 + k), 32'h300 + 32'(k));
      push(2'd0, 4'd0, 8'(60 + k), 32'h300 + 32'(k));
    end
    I_Stall = 1'b1;
    @(negedge clock);
    chk("stream_count_not_full", 64'(O_Full), 64'd0);
    chk("stream_queue_depth", 64'(exp_q.size()), 64'd7);
    step();
    push(2'd0, 4'd0, 8'd90, 32'h400);
    expect_tok(2'd0, 8'd90, 32'h400);
    @(negedge clock);
    chk("stream_count_refill", 64'(O_Full), 64'b0001);
    step();
    I_Stall = 1'b0;
    step();
    step();
    // Reset mid-stream with a push to ch1 presented in the reset cycle.
    reset         = 1'b0;
    I_Valid       = 1'b1;
    I_Ch          = 2'd1;
    I_Token_Issue = 8'd95;
    I_Token       = 32'h500;
    exp_q.delete();
    step();
    reset   = 1'b1;
    I_Valid = 1'b0;
    @(negedge clock);
    chk("midrst_valid", 64'(O_Valid), 64'd0);
    chk("midrst_full", 64'(O_Full), 64'd0);
    chk("midrst_stall", 64'(O_Stall), 64'd0);
    chk("midrst_token", 64'(O_Token), 64'd0);
    step();
    drain("midrst", 4);

`ifdef TOKEN_PIPE_NCH_FLUSH_EN
    // Flush with a simultaneous push: everything is empty afterwards.
    I_Stall    = 1'b1;
    I_Issue_No = 8'd120;
    push(2'd2, 4'd0, 8'd110, 32'hF2);
    push(2'd2, 4'd0, 8'd111, 32'hF3);
    I_Flush       = 1'b1;
    I_Valid       = 1'b1;
    I_Ch          = 2'd3;
    I_Token_Issue = 8'd112;
    I_Token       = 32'hF4;
    step();
    I_Flush = 1'b0;
    I_Valid = 1'b0;
    @(negedge clock);
    chk("flush_valid", 64'(O_Valid), 64'd0);
    chk("flush_full", 64'(O_Full), 64'd0);
    step();
    drain("flush", 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
